// File: rtl/pe_inv.sv
// pe_inv: inverse radix-2 butterfly processing element.
// Undoes the forward DIF PE. The forward PE produces sums (in0, in1) and
// twiddled differences (in2, in3). Given those and the inverse twiddle tf,
// this block recovers (x0, x1, x2, x3).
// Three-stage pipeline with one shared enable:
//   stage 1 : register the sums and the (optionally) un-twiddled differences
//   stage 2 : widened butterfly add/subtract, one extra bit of headroom
//   stage 3 : optional halving (exact inverse) or plain wrap, drive outputs
// Flow control: the whole pipe advances whenever the output register is
// empty or being consumed. Bubbles travel through the pipe as cleared
// valid bits.

module pe_inv #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 16,
   parameter int HALVE = 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] tf,
   input  logic             bypass_n,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             out_valid,
   input  logic             out_ready
);

   // ------------------------------------------------------------------
   // Pipeline control
   // ------------------------------------------------------------------
   logic en;
   logic v1_reg;
   logic v2_reg;
   logic out_valid_reg;

   // The pipe moves as a single unit: only a full, unconsumed output
   // register can hold it back.
   assign en        = !out_valid_reg | out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_reg;

   // Valid bits shift in lockstep with the data; a bubble shifts in as 0.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         v1_reg        <= 1'b0;
         v2_reg        <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (en) begin
         v1_reg        <= in_valid;
         v2_reg        <= v1_reg;
         out_valid_reg <= v2_reg;
      end
   end

   // ------------------------------------------------------------------
   // Lane inputs. Lane 0 is pair A (in0 sum, in2 difference), lane 1 is
   // pair B (in1 sum, in3 difference). Each lane yields two outputs:
   // lane 0 -> out0 (sum side), out1 (difference side)
   // lane 1 -> out2 (sum side), out3 (difference side)
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] lane_sum  [2];
   logic [WIDTH-1:0] lane_diff [2];
   logic [WIDTH-1:0] out_word  [4];

   assign lane_sum[0]  = in0;
   assign lane_sum[1]  = in1;
   assign lane_diff[0] = in2;
   assign lane_diff[1] = in3;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane

         // ---------------- stage 1: un-twiddle ----------------
         logic signed [2*WIDTH-1:0] prod;
         logic        [WIDTH-1:0]   d_next;
         logic        [WIDTH-1:0]   s_reg;
         logic        [WIDTH-1:0]   d_reg;
         logic                      unused_prod;

         // Full-precision signed product; the fixed-point result is the
         // WIDTH-bit window sitting SHIFT bits up (i.e. floor(x*tf/2^SHIFT)).
         assign prod        = $signed(lane_diff[gi]) * $signed(tf);
         assign unused_prod = ^prod;

         // Select twiddled or raw difference for this group.
         always_comb begin
            d_next = lane_diff[gi];
            if (bypass_n) begin
               d_next = prod[SHIFT+WIDTH-1:SHIFT];
            end
         end

         // Stage 1 register: sum word and un-twiddled difference.
         always_ff @(posedge Clk) begin
            if (!Reset_n) begin
               s_reg <= '0;
               d_reg <= '0;
            end else if (en) begin
               s_reg <= lane_sum[gi];
               d_reg <= d_next;
            end
         end

         // ---------------- stage 2: butterfly ----------------
         logic signed [WIDTH:0] s_ext;
         logic signed [WIDTH:0] d_ext;
         logic signed [WIDTH:0] plus_reg;
         logic signed [WIDTH:0] minus_reg;

         // One guard bit keeps the sum/difference exact before scaling.
         assign s_ext = {s_reg[WIDTH-1], s_reg};
         assign d_ext = {d_reg[WIDTH-1], d_reg};

         // Stage 2 register: widened sum and difference.
         always_ff @(posedge Clk) begin
            if (!Reset_n) begin
               plus_reg  <= '0;
               minus_reg <= '0;
            end else if (en) begin
               plus_reg  <= s_ext + d_ext;
               minus_reg <= s_ext - d_ext;
            end
         end

         // ---------------- stage 3: scale and output ----------------
         logic [WIDTH-1:0] plus_scaled;
         logic [WIDTH-1:0] minus_scaled;
         logic [WIDTH-1:0] plus_out_reg;
         logic [WIDTH-1:0] minus_out_reg;
         logic             unused_wide;

         if (HALVE != 0) begin : g_halve
            // Dropping the LSB of the widened value is an arithmetic
            // shift right by one, rounding toward -inf.
            assign plus_scaled  = plus_reg[WIDTH:1];
            assign minus_scaled = minus_reg[WIDTH:1];
         end else begin : g_wrap
            // No scaling: keep the low WIDTH bits, wrapping on overflow.
            assign plus_scaled  = plus_reg[WIDTH-1:0];
            assign minus_scaled = minus_reg[WIDTH-1:0];
         end

         assign unused_wide = ^{plus_reg, minus_reg};

         // Stage 3 register: final output words.
         always_ff @(posedge Clk) begin
            if (!Reset_n) begin
               plus_out_reg  <= '0;
               minus_out_reg <= '0;
            end else if (en) begin
               plus_out_reg  <= plus_scaled;
               minus_out_reg <= minus_scaled;
            end
         end

         assign out_word[2*gi]   = plus_out_reg;
         assign out_word[2*gi+1] = minus_out_reg;
      end
   endgenerate

   assign out0 = out_word[0];
   assign out1 = out_word[1];
   assign out2 = out_word[2];
   assign out3 = out_word[3];

endmodule

// File: tb/tb_pe_inv.sv
// Scoreboard bench for pe_inv. Two instances share the stimulus: one with
// halving (exact inverse) and one wrapping without scaling. The driver pushes
// hand-computed expectations as groups are accepted; a monitor pops and
// compares whenever an output is consumed.

module tb_pe_inv;
   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic [W-1:0]  in0, in1, in2, in3, tf;
   logic          bypass_n, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [W-1:0]  out0, out1, out2, out3;
   logic          nh_in_ready, nh_out_valid;
   logic [W-1:0]  nh_out0, nh_out1, nh_out2, nh_out3;

   always #5 Clk = ~Clk;

   pe_inv #(.WIDTH(W), .SHIFT(16), .HALVE(1)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tf(tf),
      .bypass_n(bypass_n), .in_valid(in_valid), .in_ready(in_ready),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out_valid(out_valid), .out_ready(out_ready));

   pe_inv #(.WIDTH(W), .SHIFT(16), .HALVE(0)) dut_nh (
      .Clk(Clk), .Reset_n(Reset_n),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tf(tf),
      .bypass_n(bypass_n), .in_valid(in_valid), .in_ready(nh_in_ready),
      .out0(nh_out0), .out1(nh_out1), .out2(nh_out2), .out3(nh_out3),
      .out_valid(nh_out_valid), .out_ready(out_ready));

   typedef struct {
      logic [127:0] h;     // {out0,out1,out2,out3} for HALVE=1
      logic [127:0] nh;    // same for HALVE=0
      bit           chk_lat;
      int           acc;
      int           id;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   txn        = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: compare every consumed output against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         #2;
         if (Reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_output: got %h %h %h %h, required none", out0, out1, out2, out3);
            end else begin
               e = sb.pop_front();
               txn++;
               $display("txn %0d (group %0d): out=%h %h %h %h  nh=%h %h %h %h",
                        txn, e.id, out0, out1, out2, out3, nh_out0, nh_out1, nh_out2, nh_out3);
               check("out0", out0, e.h[127:96]);
               check("out1", out1, e.h[95:64]);
               check("out2", out2, e.h[63:32]);
               check("out3", out3, e.h[31:0]);
               check("nh_valid", {31'd0, nh_out_valid}, 32'd1);
               check("nh_out0", nh_out0, e.nh[127:96]);
               check("nh_out1", nh_out1, e.nh[95:64]);
               check("nh_out2", nh_out2, e.nh[63:32]);
               check("nh_out3", nh_out3, e.nh[31:0]);
               if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'd3);
            end
         end
      end
   end

   int next_id = 0;

   // Present a group from a falling edge and hold it until accepted.
   task automatic send(input logic [W-1:0] a0, a1, a2, a3, t, input logic byp,
                       input logic [127:0] h, nh, input bit lat);
      exp_t e;
      int   g;
      @(negedge Clk);
      in0 = a0; in1 = a1; in2 = a2; in3 = a3; tf = t; bypass_n = byp; in_valid = 1'b1;
      #1;
      g = 0;
      while (!in_ready) begin
         @(negedge Clk);
         #1;
         g++;
         if (g > 200) begin
            $display("FAIL accept_timeout: in_ready stuck at 0");
            $fatal(1, "accept timeout");
         end
      end
      e.h = h; e.nh = nh; e.chk_lat = lat; e.acc = cyc; e.id = next_id;
      next_id++;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge Clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 100) begin
         @(negedge Clk);
         g++;
      end
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      end
   endtask

   // Round-trip group: forward PE model with tf=1.0, expected result is x.
   task automatic send_roundtrip(input bit lat);
      int x[4];
      logic [W-1:0] y0, y1, y2, y3;
      longint p;
      for (int k = 0; k < 4; k++) x[k] = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
      y0 = W'(x[0] + x[1]);
      y1 = W'(x[2] + x[3]);
      p  = longint'(x[0] - x[1]) * 64'sd65536;
      y2 = W'(p >>> 16);
      p  = longint'(x[2] - x[3]) * 64'sd65536;
      y3 = W'(p >>> 16);
      send(y0, y1, y2, y3, 32'h0001_0000, 1'b1,
           {W'(x[0]), W'(x[1]), W'(x[2]), W'(x[3])},
           {W'(2 * x[0]), W'(2 * x[1]), W'(2 * x[2]), W'(2 * x[3])}, lat);
   endtask

   logic [W-1:0] held [4];

   initial begin
      Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bypass_n = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0; tf = '0;
      repeat (3) @(negedge Clk);
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out0", out0, 32'd0);
      check("rst_out3", out3, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Directed vectors: in0,in1,in2,in3,tf,bypass_n -> halved / wrapped.
      send(32'd10, 32'd4, 32'd6, 32'd2, 32'h0001_0000, 1'b1,
           {32'd8, 32'd2, 32'd3, 32'd1}, {32'd16, 32'd4, 32'd6, 32'd2}, 1'b1);
      send(32'd0, 32'd7, 32'd4, 32'd7, 32'h0000_0000, 1'b0,
           {32'd2, 32'hFFFF_FFFE, 32'd7, 32'd0}, {32'd4, 32'hFFFF_FFFC, 32'd14, 32'd0}, 1'b1);
      send(32'd0, 32'd7, 32'd8, 32'd7, 32'h0000_8000, 1'b1,
           {32'd2, 32'hFFFF_FFFE, 32'd5, 32'd2}, {32'd4, 32'hFFFF_FFFC, 32'd10, 32'd4}, 1'b1);
      send(32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 32'h0000_0000, 1'b0,
           {32'h4000_0000, 32'h3FFF_FFFF, 32'd0, 32'd0},
           {32'h8000_0000, 32'h7FFF_FFFE, 32'd0, 32'd0}, 1'b1);
      send(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h0000_0000, 1'b0,
           {32'hBFFF_FFFF, 32'hC000_0000, 32'd0, 32'd0},
           {32'h7FFF_FFFF, 32'h8000_0001, 32'd0, 32'd0}, 1'b1);
      send(32'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_0000, 1'b1,
           {32'hFFFF_FFFE, 32'd3, 32'd2, 32'd0}, {32'hFFFF_FFFC, 32'd6, 32'd5, 32'd1}, 1'b1);
      send(32'd4, 32'd0, 32'hFFFF_FFFD, 32'd0, 32'h0000_8000, 1'b1,
           {32'd1, 32'd3, 32'd0, 32'd0}, {32'd2, 32'd6, 32'd0, 32'd0}, 1'b1);
      idle();
      drain();

      // Back-to-back stream of 8 round-trip groups with a 4-cycle stall.
      fork
         begin
            for (int i = 0; i < 8; i++) send_roundtrip(1'b0);
            idle();
         end
         begin
            repeat (4) @(negedge Clk);
            out_ready = 1'b0;
            #2;
            held[0] = out0; held[1] = out1; held[2] = out2; held[3] = out3;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            for (int k = 0; k < 3; k++) begin
               @(negedge Clk);
               #2;
               check("stall_valid", {31'd0, out_valid}, 32'd1);
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               check("stall_hold0", out0, held[0]);
               check("stall_hold1", out1, held[1]);
               check("stall_hold2", out2, held[2]);
               check("stall_hold3", out3, held[3]);
            end
            @(negedge Clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Fill the pipe with 3 groups against a stalled sink, then reset.
      @(negedge Clk);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_roundtrip(1'b0);
      @(negedge Clk);
      in_valid = 1'b0;
      #2;
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      out_ready = 1'b1;
      sb.delete();
      #2;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out0", out0, 32'd0);
      check("midrst_out1", out1, 32'd0);
      check("midrst_out2", out2, 32'd0);
      check("midrst_out3", out3, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         #2;
         check("no_stale", {31'd0, out_valid}, 32'd0);
      end
      send_roundtrip(1'b1);
      idle();
      drain();

      // A few more round trips back-to-back.
      for (int i = 0; i < 4; i++) send_roundtrip(1'b1);
      idle();
      drain();

      repeat (3) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
